// File: rtl/test_card_sequencer.sv
// test_card_sequencer: chooses the active test card, fades it in and out, and maps screen coordinates to card coordinates.
// Latency: the coordinate path takes 1 cycle. Card, level and state step once on each clock edge that has i_frame=1.
// Backpressure: none. i_next is a level request, acknowledged with a 1-cycle o_next_ack pulse, and ignored while fading or already pending.
// Optional: when TEST_CARD_SCROLL_EN is defined, a per-frame vertical scroll offset is added to o_y.
module test_card_sequencer #(
    parameter int CORDW       = 16,
    parameter int NUM_CARDS   = 4,
    parameter int HOLD_FRAMES = 120,
    parameter int X_SHIFT     = 4,
    parameter int Y_SHIFT     = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_frame,
    input  logic                         i_de,
    input  logic [CORDW-1:0]             i_sx,
    input  logic [CORDW-1:0]             i_sy,
    input  logic                         i_next,
    output logic                         o_next_ack,
    output logic [$clog2(NUM_CARDS)-1:0] o_card,
    output logic [3:0]                   o_level,
    output logic                         o_busy,
    output logic [5:0]                   o_x,
    output logic [7:0]                   o_y,
    output logic                         o_valid
);

    localparam int CARDW = $clog2(NUM_CARDS);
    localparam int HOLDW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CARDW-1:0] LAST_CARD = CARDW'(NUM_CARDS - 1);
    localparam logic [HOLDW-1:0] LAST_HOLD = HOLDW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        HOLD     = 2'd1,
        FADE_OUT = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       level_q;
    logic [CARDW-1:0] card_q;
    logic [HOLDW-1:0] hold_cnt_q;
    logic             pending_q;
    logic             ack_q;
    logic             busy_q;

    logic             accept_d;
    logic             hold_exit_d;

    logic [CORDW-1:0] x_shift_d;
    logic [CORDW-1:0] y_shift_d;
    logic [5:0]       x_d;
    logic [7:0]       y_sat_d;
    logic [7:0]       y_d;
    logic [5:0]       x_q;
    logic [7:0]       y_q;
    logic             valid_q;

`ifdef TEST_CARD_SCROLL_EN
    logic [7:0]       scroll_q;
`endif

    // A manual request is taken at most once per HOLD period. HOLD ends on a frame when the hold time expires or a request is pending.
    always_comb begin
        accept_d    = (state_q == HOLD) && !pending_q && i_next;
        hold_exit_d = (state_q == HOLD) && ((hold_cnt_q == LAST_HOLD) || pending_q);
    end

    // Fade/hold sequencer: only steps on frame edges so card and level never change mid-frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= FADE_IN;
            level_q    <= 4'd0;
            card_q     <= '0;
            hold_cnt_q <= '0;
            pending_q  <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            ack_q <= accept_d;
            if (i_frame) begin
                unique case (state_q)
                    FADE_IN: begin
                        if (level_q == 4'd15) begin
                            state_q    <= HOLD;
                            hold_cnt_q <= '0;
                            busy_q     <= 1'b0;
                        end else begin
                            level_q <= level_q + 4'd1;
                        end
                    end
                    HOLD: begin
                        if (hold_exit_d) begin
                            state_q <= FADE_OUT;
                            busy_q  <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    FADE_OUT: begin
                        if (level_q == 4'd0) begin
                            card_q  <= (card_q == LAST_CARD) ? '0 : card_q + 1'b1;
                            state_q <= FADE_IN;
                        end else begin
                            level_q <= level_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q <= FADE_IN;
                        busy_q  <= 1'b1;
                    end
                endcase
            end
            // A request accepted on the same edge as the exit still sets pending.
            // It is then cleared by the following HOLD exit.
            if (accept_d) begin
                pending_q <= 1'b1;
            end else if (i_frame && hold_exit_d) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Coordinate mapping: shift down, then saturate so that large screen coordinates clamp instead of wrapping.
    always_comb begin
        x_shift_d = i_sx >> X_SHIFT;
        y_shift_d = i_sy >> Y_SHIFT;
        x_d       = (x_shift_d > CORDW'(63))  ? 6'd63  : x_shift_d[5:0];
        y_sat_d   = (y_shift_d > CORDW'(255)) ? 8'd255 : y_shift_d[7:0];
`ifdef TEST_CARD_SCROLL_EN
        y_d       = y_sat_d + scroll_q;
`else
        y_d       = y_sat_d;
`endif
    end

    // Coordinate pipeline register: updated every cycle whether or not display enable is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_q     <= 6'd0;
            y_q     <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= i_de;
        end
    end

`ifdef TEST_CARD_SCROLL_EN
    // Vertical scroll offset: advances once per frame and wraps naturally at 8 bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scroll_q <= 8'd0;
        end else if (i_frame) begin
            scroll_q <= scroll_q + 8'd1;
        end
    end
`endif

    assign o_next_ack = ack_q;
    assign o_card     = card_q;
    assign o_level    = level_q;
    assign o_busy     = busy_q;
    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_test_card_sequencer.sv
// tb_test_card_sequencer: scoreboard bench for test_card_sequencer, built with HOLD_FRAMES=4 and NUM_CARDS=4.
// Latency: each drive_cycle pushes the expected post-edge outputs, which are popped and compared 1 ns after the edge.
// Backpressure: not applicable. Frames are pulsed every 4 cycles.
module tb_test_card_sequencer;

    localparam int HF = 4;
    localparam int NC = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_frame = 1'b0;
    logic        i_de = 1'b0;
    logic [15:0] i_sx = 16'd0;
    logic [15:0] i_sy = 16'd0;
    logic        i_next = 1'b0;
    logic        o_next_ack;
    logic [1:0]  o_card;
    logic [3:0]  o_level;
    logic        o_busy;
    logic [5:0]  o_x;
    logic [7:0]  o_y;
    logic        o_valid;

    test_card_sequencer #(
        .CORDW(16), .NUM_CARDS(NC), .HOLD_FRAMES(HF), .X_SHIFT(4), .Y_SHIFT(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame(i_frame), .i_de(i_de),
        .i_sx(i_sx), .i_sy(i_sy), .i_next(i_next), .o_next_ack(o_next_ack),
        .o_card(o_card), .o_level(o_level), .o_busy(o_busy), .o_x(o_x),
        .o_y(o_y), .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] card;
        logic [3:0] level;
        logic       busy;
        logic       ack;
        logic [5:0] x;
        logic [7:0] y;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   fno = 0;

    // Reference model state
    typedef enum int {M_FI, M_HOLD, M_FO} mst_t;
    mst_t       m_st = M_FI;
    int         m_lvl = 0;
    logic [1:0] m_card = 2'd0;
    int         m_hold = 0;
    logic       m_pend = 1'b0;
    logic [7:0] m_scroll = 8'd0;

    function automatic exp_t dut_obs();
        exp_t o;
        o.card  = o_card;
        o.level = o_level;
        o.busy  = o_busy;
        o.ack   = o_next_ack;
        o.x     = o_x;
        o.y     = o_y;
        o.valid = o_valid;
        return o;
    endfunction

    // Drive one cycle of stimulus, push the expected outputs for the following edge, then return 1 ns after that edge.
    task automatic drive_cycle(input logic rst_n, input logic frame, input logic nxt,
                               input logic de, input logic [15:0] sx, input logic [15:0] sy);
        exp_t        e;
        logic        acc;
        logic [15:0] xs;
        logic [15:0] ys;
        logic [7:0]  yv;
        @(negedge i_clk);
        i_rst_n = rst_n; i_frame = frame; i_next = nxt; i_de = de; i_sx = sx; i_sy = sy;
        e  = '0;
        xs = sx >> 4;
        ys = sy >> 1;
        if (!rst_n) begin
            m_st = M_FI; m_lvl = 0; m_card = 2'd0; m_hold = 0; m_pend = 1'b0; m_scroll = 8'd0;
            e.busy = 1'b1;
        end else begin
            e.x = (xs > 16'd63) ? 6'd63 : xs[5:0];
            yv  = (ys > 16'd255) ? 8'd255 : ys[7:0];
`ifdef TEST_CARD_SCROLL_EN
            yv = yv + m_scroll;
            if (frame) m_scroll = m_scroll + 8'd1;
`endif
            e.y     = yv;
            e.valid = de;
            acc = (m_st == M_HOLD) && !m_pend && nxt;
            if (frame) begin
                case (m_st)
                    M_FI: if (m_lvl == 15) begin m_st = M_HOLD; m_hold = 0; end
                          else m_lvl = m_lvl + 1;
                    M_HOLD: if (m_hold == HF - 1 || m_pend) begin m_st = M_FO; m_pend = 1'b0; end
                            else m_hold = m_hold + 1;
                    default: if (m_lvl == 0) begin m_card = (m_card == 2'(NC - 1)) ? 2'd0 : m_card + 2'd1; m_st = M_FI; end
                             else m_lvl = m_lvl - 1;
                endcase
            end
            if (acc) m_pend = 1'b1;
            e.card  = m_card;
            e.level = 4'(m_lvl);
            e.busy  = (m_st != M_HOLD);
            e.ack   = acc;
        end
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t rst_val;
        rst_val = '0;
        rst_val.busy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'd639, 16'd479);
            e = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== e || e !== rst_val) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h want %h", c, dut_obs(), rst_val);
            end
        end
        fno = 0;
    endtask

    task automatic test_fade_in();
        exp_t e;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, 1'b0, 1'($urandom_range(0, 1)),
                            16'($urandom_range(0, 2047)), 16'($urandom_range(0, 1023)));
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL fade_in frame %0d cyc %0d: got %h want %h", fno, c, dut_obs(), e);
                end
            end
            if (fno == 15) begin
                n_checks++;
                if ({o_busy, o_level} !== {1'b1, 4'd15}) begin
                    n_fail++;
                    $display("FAIL fade_in_f15 busy/level got %b/%0d want 1/15", o_busy, o_level);
                end
            end
            if (fno == 16) begin
                n_checks++;
                if ({o_busy, o_card, o_level} !== {1'b0, 2'd0, 4'd15}) begin
                    n_fail++;
                    $display("FAIL hold_entry busy/card/level got %b/%0d/%0d want 0/0/15", o_busy, o_card, o_level);
                end
            end
        end
    endtask

    task automatic test_auto_advance();
        exp_t e;
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, 1'b0, 1'b1,
                            16'($urandom_range(0, 2047)), 16'($urandom_range(0, 1023)));
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL auto_adv frame %0d cyc %0d: got %h want %h", fno, c, dut_obs(), e);
                end
            end
            if (fno == 19 || fno == 20) begin
                n_checks++;
                if ({o_busy, o_level} !== {(fno == 20), 4'd15}) begin
                    n_fail++;
                    $display("FAIL fade_out_start frame %0d busy/level got %b/%0d want %0d/15", fno, o_busy, o_level, fno == 20);
                end
            end
            if (fno == 35 || fno == 36) begin
                n_checks++;
                if ({o_card, o_level} !== {(fno == 36) ? 2'd1 : 2'd0, 4'd0}) begin
                    n_fail++;
                    $display("FAIL card_advance frame %0d card/level got %0d/%0d", fno, o_card, o_level);
                end
            end
        end
    endtask

    task automatic test_card_wrap();
        exp_t e;
        for (int f = 0; f < 108; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, 1'b0, 1'b1,
                            16'($urandom_range(0, 4095)), 16'($urandom_range(0, 1023)));
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL wrap frame %0d cyc %0d: got %h want %h", fno, c, dut_obs(), e);
                end
            end
            if (fno == 108 || fno == 144) begin
                n_checks++;
                if (o_card !== ((fno == 108) ? 2'd3 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL card_wrap frame %0d card got %0d", fno, o_card);
                end
            end
        end
    endtask

    task automatic test_next_held();
        exp_t e;
        int   acks;
        // Fade card 0 in: frames 145..160, which leaves the sequencer in HOLD.
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, 1'b0, 1'b1, 16'd100, 16'd100);
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL next_held_fadein frame %0d: got %h want %h", fno, dut_obs(), e);
                end
            end
        end
        acks = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) fno++;
            drive_cycle(1'b1, c == 6, 1'b1, 1'b1, 16'd100, 16'd100);
            if (o_next_ack === 1'b1) acks++;
            e = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL next_held cyc %0d: got %h want %h", c, dut_obs(), e);
            end
        end
        n_checks++;
        if (acks !== 1 || o_busy !== 1'b1 || o_level !== 4'd15) begin
            n_fail++;
            $display("FAIL next_held_ack acks/busy/level got %0d/%b/%0d want 1/1/15", acks, o_busy, o_level);
        end
    endtask

    task automatic test_next_ignored();
        exp_t e;
        int   acks;
        acks = 0;
        // i_next is held high through frames 162..192, covering both the FADE_OUT and the FADE_IN phases.
        for (int f = 0; f < 31; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, 1'b1, 1'b0, 16'd5, 16'd5);
                if (o_next_ack === 1'b1) acks++;
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL next_ignored frame %0d: got %h want %h", fno, dut_obs(), e);
                end
            end
        end
        n_checks++;
        if (acks !== 0 || o_card !== 2'd1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL next_ignored_sum acks/card/busy got %0d/%0d/%b want 0/1/1", acks, o_card, o_busy);
        end
    endtask

    task automatic test_next_with_expiry();
        exp_t e;
        int   acks;
        acks = 0;
        // Frame 193 enters HOLD, frames 194..196 count the hold time, and frame 197 is the expiry, which coincides with i_next.
        for (int f = 0; f < 21; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, (fno == 197 && c == 0), 1'b1, 16'd7, 16'd7);
                if (o_next_ack === 1'b1) acks++;
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL next_expiry frame %0d cyc %0d: got %h want %h", fno, c, dut_obs(), e);
                end
            end
        end
        n_checks++;
        if (acks !== 1 || o_card !== 2'd2 || o_level !== 4'd0) begin
            n_fail++;
            $display("FAIL next_expiry_sum acks/card/level got %0d/%0d/%0d want 1/2/0", acks, o_card, o_level);
        end
    endtask

    task automatic test_reset_midfade();
        exp_t e;
        exp_t rst_val;
        rst_val = '0;
        rst_val.busy = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        void'(exp_q.pop_front());
        fno = 0;
        for (int f = 0; f < 100; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) fno++;
                drive_cycle(1'b1, c == 0, 1'b0, 1'b1, 16'd320, 16'd240);
                e = exp_q.pop_front();
                n_checks++;
                if (dut_obs() !== e) begin
                    n_fail++;
                    $display("FAIL midfade_run frame %0d: got %h want %h", fno, dut_obs(), e);
                end
            end
        end
        n_checks++;
        if ({o_card, o_level, o_busy} !== {2'd2, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL midfade_point card/level/busy got %0d/%0d/%b want 2/7/1", o_card, o_level, o_busy);
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'd639, 16'd479);
        e = exp_q.pop_front();
        n_checks++;
        if (dut_obs() !== rst_val || e !== rst_val) begin
            n_fail++;
            $display("FAIL midfade_reset got %h want %h", dut_obs(), rst_val);
        end
        fno = 0;
    endtask

    task automatic test_coords();
        exp_t        e;
        logic [15:0] sxs[6];
        logic [15:0] sys[6];
        logic [5:0]  txs[6];
        logic [7:0]  tys[6];
        sxs = '{16'd639, 16'd2000, 16'd1023, 16'd1024, 16'd0, 16'hFFFF};
        sys = '{16'd479, 16'd900,  16'd511,  16'd512,  16'd1, 16'hFFFF};
        txs = '{6'd39, 6'd63, 6'd63, 6'd63, 6'd0, 6'd63};
        tys = '{8'd239, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'(i % 2 == 0), sxs[i], sys[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== e || {o_x, o_y, o_valid} !== {txs[i], tys[i], 1'(i % 2 == 0)}) begin
                n_fail++;
                $display("FAIL coord %0d x/y/valid got %0d/%0d/%b want %0d/%0d/%b",
                         i, o_x, o_y, o_valid, txs[i], tys[i], i % 2 == 0);
            end
        end
`ifdef TEST_CARD_SCROLL_EN
        for (int f = 0; f < 20; f++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
            e = exp_q.pop_front();
            n_checks++;
            if (dut_obs() !== e) begin
                n_fail++;
                $display("FAIL scroll_run %0d: got %h want %h", f, dut_obs(), e);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'd639, 16'd479);
        e = exp_q.pop_front();
        n_checks++;
        if (o_y !== 8'd3 || dut_obs() !== e) begin
            n_fail++;
            $display("FAIL scroll_y got %0d want 3", o_y);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_auto_advance();
        test_card_wrap();
        test_next_held();
        test_next_ignored();
        test_next_with_expiry();
        test_reset_midfade();
        test_coords();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
